// File: rtl/pc_fetch_ctrl_pkg.sv
// lc3b_types: shared types for the fetch front end and the datapath.
//   lc3b_word        16-bit machine word / address
//   lc3b_nzp         3-bit condition mask, {n, z, p}
//   pc_fetch_state_t fetch controller states
//   align_target()   forces a branch target onto a word boundary
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_nzp;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } pc_fetch_state_t;

    localparam lc3b_word PC_STEP = 16'd2;

    function automatic lc3b_word align_target(input lc3b_word t);
        return {t[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_br_cond_eval.sv
// br_cond_eval: combinational branch-condition resolver, shared with the
// datapath.
//   br_nzp_i  branch condition mask (IR[11:9])
//   cc_nzp_i  current condition codes, one-hot n/z/p
//   taken_o   1 when any selected condition code is set
module br_cond_eval
    import lc3b_types::*;
(
    input  lc3b_nzp br_nzp_i,
    input  lc3b_nzp cc_nzp_i,
    output logic    taken_o
);

    assign taken_o = |(br_nzp_i & cc_nzp_i);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, fetches instruction words over
// the mem_read/mem_resp handshake, hands them to decode over ir_valid/ir_ready
// and redirects the fetch stream on taken branches.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   br_valid/br_ready       branch resolution handshake
//   br_nzp, cc_nzp          branch mask and current condition codes
//   br_target               branch target from the external adder
//   mem_address, mem_read   fetch request (held until mem_resp)
//   mem_resp, mem_rdata     one-cycle response pulse and data
//   ir_valid/ir_ready       instruction handshake to decode
//   ir_data, ir_pc          instruction word and its fetch address + 2
//   pc_out                  current PC register
//   misalign                (only with PC_FETCH_ALIGN_CHECK_EN) sticky flag,
//                           set by an accepted taken branch to an odd target
//
// Build option: define PC_FETCH_ALIGN_CHECK_EN to add the misalign port.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | request outstanding at pc; waits for mem_resp
// HOLD  | instruction presented to decode; waits for ir_ready or a branch
// DROP  | one-cycle bubble after a redirected (discarded) fetch
module pc_fetch_ctrl
    import lc3b_types::*;
#(
    parameter lc3b_word PC_RESET = 16'h0000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     br_valid,
    output logic     br_ready,
    input  lc3b_nzp  br_nzp,
    input  lc3b_nzp  cc_nzp,
    input  lc3b_word br_target,
    output lc3b_word mem_address,
    output logic     mem_read,
    input  logic     mem_resp,
    input  lc3b_word mem_rdata,
    output logic     ir_valid,
    input  logic     ir_ready,
    output lc3b_word ir_data,
    output lc3b_word ir_pc,
    output lc3b_word pc_out
`ifdef PC_FETCH_ALIGN_CHECK_EN
    ,
    output logic     misalign
`endif
);

    pc_fetch_state_t state_q, state_d;
    lc3b_word        pc_q, pc_d;
    lc3b_word        ir_data_q, ir_data_d;
    lc3b_word        ir_pc_q, ir_pc_d;
    logic            redir_q, redir_d;
    lc3b_word        redir_tgt_q, redir_tgt_d;
    // Low for the first cycle after reset so the first request starts one
    // cycle after rst_n deasserts.
    logic            run_q;

    logic            br_taken;
    logic            br_take;
    lc3b_word        tgt_now;

    br_cond_eval u_br_cond_eval (
        .br_nzp_i (br_nzp),
        .cc_nzp_i (cc_nzp),
        .taken_o  (br_taken)
    );

    assign tgt_now = align_target(br_target);
    assign br_take = br_valid & br_ready & br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= PC_RESET;
            ir_data_q   <= '0;
            ir_pc_q     <= '0;
            redir_q     <= 1'b0;
            redir_tgt_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_data_q   <= ir_data_d;
            ir_pc_q     <= ir_pc_d;
            redir_q     <= redir_d;
            redir_tgt_q <= redir_tgt_d;
            run_q       <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_data_d   = ir_data_q;
        ir_pc_d     = ir_pc_q;
        redir_d     = redir_q;
        redir_tgt_d = redir_tgt_q;
        mem_read    = 1'b0;
        // A pending redirect blocks further branches until it is consumed.
        br_ready    = rst_n & ~redir_q;

        unique case (state_q)
            FETCH: begin
                mem_read = run_q;
                if (run_q && mem_resp) begin
                    if (redir_q) begin
                        pc_d    = redir_tgt_q;
                        redir_d = 1'b0;
                        state_d = DROP;
                    end else if (br_take) begin
                        pc_d    = tgt_now;
                        state_d = DROP;
                    end else begin
                        ir_data_d = mem_rdata;
                        ir_pc_d   = pc_q + PC_STEP;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = HOLD;
                    end
                end else if (br_take) begin
                    // Request must stay stable; remember where to go once
                    // the in-flight word comes back.
                    redir_d     = 1'b1;
                    redir_tgt_d = tgt_now;
                end
            end
            HOLD: begin
                if (br_take) begin
                    pc_d    = tgt_now;
                    state_d = FETCH;
                end else if (ir_ready) begin
                    state_d = FETCH;
                end
            end
            DROP: begin
                // Nothing is in flight here, so a branch can load pc directly.
                if (br_take) begin
                    pc_d = tgt_now;
                end
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign mem_address = pc_q;
    assign ir_valid    = (state_q == HOLD);
    assign ir_data     = ir_data_q;
    assign ir_pc       = ir_pc_q;
    assign pc_out      = pc_q;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (br_take && br_target[0]) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC and fetches instructions from memory using the mem_read/mem_resp handshake.
- Presents each fetched instruction to decode through a valid/ready handshake.
- Sits on the consuming end of the branch-target path: it receives the target computed from PC + SEXT(offset), resolves taken/not-taken from NZP, and redirects the fetch stream.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  branch resolution request.
- br_ready  out  1  branch request accepted when br_valid & br_ready.
- br_nzp  in  3  branch condition mask, IR[11:9].
- cc_nzp  in  3  current condition codes, one-hot n/z/p.
- br_target  in  16  branch target address.
- mem_address  out  16  instruction fetch address.
- mem_read  out  1  fetch request.
- mem_resp  in  1  one-cycle pulse; mem_rdata is valid in that cycle.
- mem_rdata  in  16  fetched instruction word.
- ir_valid  out  1  ir_data/ir_pc hold a valid instruction.
- ir_ready  in  1  decode accepts the instruction.
- ir_data  out  16  instruction word.
- ir_pc  out  16  incremented PC (fetch address + 2), the base for branch targets.
- pc_out  out  16  current PC register.

Behaviour:
- Reset (async, rst_n=0):
  - pc=PC_RESET, state=FETCH, mem_read=0, ir_valid=0, ir_data=0, ir_pc=0, br_ready=0, pending redirect cleared.
  - mem_read first asserts in the cycle after rst_n deasserts.
- States: FETCH, HOLD, DROP.
- FETCH:
  - mem_read=1 and mem_address=pc, both held stable until mem_resp.
  - On mem_resp with no redirect pending and no taken branch this cycle: ir_data<=mem_rdata, ir_pc<=pc+2, pc<=pc+2, go HOLD.
  - On mem_resp with redirect pending, or with a taken branch accepted the same cycle: discard mem_rdata, pc<=target, go DROP.
- HOLD:
  - mem_read=0, ir_valid=1.
  - ir_valid & ir_ready -> go FETCH.
  - A taken branch accepted in HOLD: ir_valid<=0, pc<=target, go FETCH. This also applies when ir_ready is high the same cycle; the branch wins and the outcome is identical.
- DROP:
  - One bubble cycle: mem_read=0, ir_valid=0, then go FETCH.
- Memory handshake:
  - mem_read is always low for at least one cycle between successive requests.
  - A request is never withdrawn before mem_resp.
- Branch handshake:
  - br_ready=1 in every state except while a redirect is pending, or when rst_n is low.
  - taken = |(br_nzp & cc_nzp). br_nzp=3'b000 is never taken; 3'b111 is always taken.
  - A not-taken branch is accepted with no effect.
- Taken branch accepted in FETCH before mem_resp: latch target as the pending redirect; br_ready=0 until it is consumed at mem_resp.
- Target alignment: target[0] is always cleared before loading pc.
- Arithmetic: pc+2 is 16-bit and wraps, so 16'hFFFE -> 16'h0000.
- pc_out reflects the pc register at all times.
- Reset asserted mid-fetch:
  - Immediately abandons the request and any pending redirect; mem_read drops asynchronously.
  - The environment must discard any in-flight mem_resp.

Optional Feature:
- Macro PC_FETCH_ALIGN_CHECK_EN.
- Defined: adds output port misalign (1 bit, reset 0). It is a sticky flag, set when an accepted taken branch has br_target[0]=1, and cleared only by reset. The fetch still uses {br_target[15:1],1'b0}.
- Not defined: no port is added, and target[0] is cleared silently.

Decomposition:
- Shared package lc3b_types holds:
  - lc3b_word (16-bit)
  - lc3b_nzp (3-bit)
  - the fetch state enum pc_fetch_state_t {FETCH, HOLD, DROP}
- Natural sub-module br_cond_eval: combinational taken = |(br_nzp & cc_nzp). It is reused by the datapath.
- The existing branch-target adder stays external and drives br_target.

Test Plan:
- Reset with PC_RESET=16'h3000, memory latency 2 cycles, ir_ready=1 -> addresses 3000, 3002, 3004 in order; mem_read low one cycle between requests; ir_pc 3002, 3004, 3006.
- In HOLD with ir_data=16'h0E05, br_nzp=111, cc=010, br_target=16'h4010 -> ir_valid drops, next mem_address=4010.
- In FETCH with memory stalled 3 cycles, taken branch to 16'h5000 -> br_ready=0 until mem_resp, returned data is never presented, DROP bubble, next mem_address=5000.
- br_nzp=100 with cc=001 -> accepted, not taken; fetch continues at pc+2; no ir_valid glitch.
- pc=16'hFFFE, fetch completes -> ir_pc=0000, next mem_address=0000.
- PC_FETCH_ALIGN_CHECK_EN defined, taken branch to 16'h6001 -> misalign=1 and stays high; mem_address=6000; rst_n pulse clears misalign and restores PC_RESET.
